// File: rtl/dsa_simd_pkg.sv
// Shared types and defaults for the SIMD pixel buffer between pixel fetch and bilinear interpolation.
package dsa_simd_pkg;

    localparam int DSA_PIX_W_DEF = 8;
    localparam int DSA_LANES_DEF = 4;

    typedef logic [DSA_PIX_W_DEF-1:0] pix_t;

    typedef struct packed {
        pix_t p00;
        pix_t p01;
        pix_t p10;
        pix_t p11;
    } quad_t;

endpackage

// File: rtl/dsa_simd_fifo_ctrl.sv
// Pointer, occupancy and flush control for dsa_simd_fifo.
// Optional high-water mark port enabled by DSA_SIMD_FIFO_HWM_EN.
module dsa_simd_fifo_ctrl
    import dsa_simd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1),
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic             in_ready,
    output logic             out_valid,
    output logic             push,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count
`ifdef DSA_SIMD_FIFO_HWM_EN
    ,
    output logic [CNT_W-1:0] hwm
`endif
);

    logic             pop;
    logic [CNT_W-1:0] count_nxt;

    // Handshakes depend only on registered occupancy, never on the opposite side.
    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_nxt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

`ifdef DSA_SIMD_FIFO_HWM_EN
    // Survives flush so software can read peak occupancy across flushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hwm <= '0;
        end else if (count_nxt > hwm) begin
            hwm <= count_nxt;
        end
    end
`endif

endmodule

// File: rtl/dsa_simd_fifo.sv
// Show-ahead SIMD vector FIFO: N lanes of 2x2 pixel neighbourhoods plus lane mask per entry.
// Define DSA_SIMD_FIFO_HWM_EN to add the hwm (high-water mark) output.
module dsa_simd_fifo
    import dsa_simd_pkg::*;
#(
    parameter int N     = DSA_LANES_DEF,
    parameter int PIX_W = DSA_PIX_W_DEF,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_mask,
    input  logic [PIX_W-1:0] in_p00 [0:N-1],
    input  logic [PIX_W-1:0] in_p01 [0:N-1],
    input  logic [PIX_W-1:0] in_p10 [0:N-1],
    input  logic [PIX_W-1:0] in_p11 [0:N-1],
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_mask,
    output logic [PIX_W-1:0] out_p00 [0:N-1],
    output logic [PIX_W-1:0] out_p01 [0:N-1],
    output logic [PIX_W-1:0] out_p10 [0:N-1],
    output logic [PIX_W-1:0] out_p11 [0:N-1],
    output logic [CNT_W-1:0] count
`ifdef DSA_SIMD_FIFO_HWM_EN
    ,
    output logic [CNT_W-1:0] hwm
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [PIX_W-1:0] p00;
        logic [PIX_W-1:0] p01;
        logic [PIX_W-1:0] p10;
        logic [PIX_W-1:0] p11;
    } lane_t;

    logic             push;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    lane_t            mem      [0:DEPTH-1][0:N-1];
    logic [N-1:0]     mem_mask [0:DEPTH-1];

    dsa_simd_fifo_ctrl #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .PTR_W (PTR_W)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .push      (push),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .count     (count)
`ifdef DSA_SIMD_FIFO_HWM_EN
        ,
        .hwm       (hwm)
`endif
    );

    // Storage is zeroed on reset so the head reads as all-zero until the first push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < DEPTH; d++) begin
                mem_mask[d] <= '0;
                for (int l = 0; l < N; l++) begin
                    mem[d][l] <= '0;
                end
            end
        end else if (push) begin
            mem_mask[wr_ptr] <= in_mask;
            for (int l = 0; l < N; l++) begin
                mem[wr_ptr][l] <= '{p00: in_p00[l], p01: in_p01[l],
                                    p10: in_p10[l], p11: in_p11[l]};
            end
        end
    end

    always_comb begin
        out_mask = mem_mask[rd_ptr];
        for (int l = 0; l < N; l++) begin
            out_p00[l] = mem[rd_ptr][l].p00;
            out_p01[l] = mem[rd_ptr][l].p01;
            out_p10[l] = mem[rd_ptr][l].p10;
            out_p11[l] = mem[rd_ptr][l].p11;
        end
    end

endmodule

// File: tb/tb_dsa_simd_fifo.sv
// Directed bench for dsa_simd_fifo with a queue-based reference model checked every cycle.
module tb_dsa_simd_fifo;

    localparam int N     = 4;
    localparam int PIX_W = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_mask;
    logic [PIX_W-1:0] in_p00 [0:N-1];
    logic [PIX_W-1:0] in_p01 [0:N-1];
    logic [PIX_W-1:0] in_p10 [0:N-1];
    logic [PIX_W-1:0] in_p11 [0:N-1];
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_mask;
    logic [PIX_W-1:0] out_p00 [0:N-1];
    logic [PIX_W-1:0] out_p01 [0:N-1];
    logic [PIX_W-1:0] out_p10 [0:N-1];
    logic [PIX_W-1:0] out_p11 [0:N-1];
    logic [CNT_W-1:0] count;
`ifdef DSA_SIMD_FIFO_HWM_EN
    logic [CNT_W-1:0] hwm;
`endif

    int checks = 0;
    int errors = 0;

    // reference model: queue of accepted vector ids and their masks
    int           q_id   [$];
    logic [N-1:0] q_mask [$];
    int           m_hwm = 0;
    int           drv_id = 0;

    dsa_simd_fifo #(.N(N), .PIX_W(PIX_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mask   (in_mask),
        .in_p00    (in_p00),
        .in_p01    (in_p01),
        .in_p10    (in_p10),
        .in_p11    (in_p11),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mask  (out_mask),
        .out_p00   (out_p00),
        .out_p01   (out_p01),
        .out_p10   (out_p10),
        .out_p11   (out_p11),
        .count     (count)
`ifdef DSA_SIMD_FIFO_HWM_EN
        ,
        .hwm       (hwm)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [PIX_W-1:0] pix(input int k, input int l, input int s);
        return PIX_W'((k * 16 + l) ^ (s * 64));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_vec(input int k, input logic [N-1:0] m);
        drv_id  = k;
        in_mask = m;
        for (int l = 0; l < N; l++) begin
            in_p00[l] = pix(k, l, 0);
            in_p01[l] = pix(k, l, 1);
            in_p10[l] = pix(k, l, 2);
            in_p11[l] = pix(k, l, 3);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Model update: FIFO semantics stated directly on a queue.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q_id.delete();
            q_mask.delete();
            m_hwm = 0;
        end else begin
            if (flush) begin
                q_id.delete();
                q_mask.delete();
            end else begin
                bit do_push;
                bit do_pop;
                do_push = in_valid && (q_id.size() < DEPTH);
                do_pop  = out_ready && (q_id.size() > 0);
                if (do_pop) begin
                    void'(q_id.pop_front());
                    void'(q_mask.pop_front());
                end
                if (do_push) begin
                    q_id.push_back(drv_id);
                    q_mask.push_back(in_mask);
                end
            end
            if (q_id.size() > m_hwm) m_hwm = q_id.size();
        end
    end

    // Compare process on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("count", 32'(count), 32'(q_id.size()));
            chk("out_valid", 32'(out_valid), 32'(q_id.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(q_id.size() < DEPTH));
`ifdef DSA_SIMD_FIFO_HWM_EN
            chk("hwm", 32'(hwm), 32'(m_hwm));
`endif
            if (q_id.size() != 0) begin
                chk("out_mask", 32'(out_mask), 32'(q_mask[0]));
                for (int l = 0; l < N; l++) begin
                    chk("out_p00", 32'(out_p00[l]), 32'(pix(q_id[0], l, 0)));
                    chk("out_p01", 32'(out_p01[l]), 32'(pix(q_id[0], l, 1)));
                    chk("out_p10", 32'(out_p10[l]), 32'(pix(q_id[0], l, 2)));
                    chk("out_p11", 32'(out_p11[l]), 32'(pix(q_id[0], l, 3)));
                end
            end
        end
    end

    logic [9:0] vpat;
    logic [9:0] rpat;
    logic [7:0] head_exp [0:2];

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_vec(0, '0);
        #12;
        rst = 1'b0;
        step();
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_p00", 32'(out_p00[3]), 32'd0);

        // 1. fill: five pushes, fifth refused
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_vec(k, 4'b1111);
            step();
        end
        in_valid = 1'b0;
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_head_p00_2", 32'(out_p00[2]), 32'h02);

        // 2. drain in order
        head_exp = '{8'h10, 8'h20, 8'h30};
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            step();
            if (j < 3) chk("drain_head_p00_0", 32'(out_p00[0]), 32'(head_exp[j]));
        end
        chk("drain_out_valid", 32'(out_valid), 32'd0);
        chk("drain_count", 32'(count), 32'd0);

        // 3. streaming from empty
        in_valid = 1'b1;
        for (int k = 10; k < 16; k++) begin
            set_vec(k, 4'(k));
            step();
            chk("stream_count", 32'(count), 32'd1);
            chk("stream_in_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_empty", 32'(count), 32'd0);

        // 4. wrap with stalls
        vpat = 10'b1101101111;
        rpat = 10'b1011010110;
        for (int c = 0; c < 10; c++) begin
            in_valid  = vpat[c];
            out_ready = rpat[c];
            set_vec(20 + c, (c == 0) ? 4'b1010 : 4'(c));
            step();
            if (c == 0) chk("mask_roundtrip", 32'(out_mask), 32'b1010);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) step();
        chk("wrap_drained", 32'(count), 32'd0);

        // 5. flush with concurrent push
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 30; k < 33; k++) begin
            set_vec(k, 4'b0101);
            step();
        end
        chk("preflush_count", 32'(count), 32'd3);
        flush = 1'b1;
        set_vec(40, 4'b1111);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b1;
        set_vec(41, 4'b0011);
        step();
        in_valid = 1'b0;
        chk("postflush_head_p00", 32'(out_p00[0]), 32'h90);
        out_ready = 1'b1;
        step();
        chk("postflush_empty", 32'(out_valid), 32'd0);

        // 6. async reset mid-burst
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 50; k < 52; k++) begin
            set_vec(k, 4'b1100);
            step();
        end
        in_valid = 1'b0;
        chk("prereset_count", 32'(count), 32'd2);
        #1 rst = 1'b1;
        #1;
        chk("areset_out_valid", 32'(out_valid), 32'd0);
        chk("areset_count", 32'(count), 32'd0);
        chk("areset_out_mask", 32'(out_mask), 32'd0);
        for (int l = 0; l < N; l++) begin
            chk("areset_out_p00", 32'(out_p00[l]), 32'd0);
            chk("areset_out_p11", 32'(out_p11[l]), 32'd0);
        end
`ifdef DSA_SIMD_FIFO_HWM_EN
        chk("areset_hwm", 32'(hwm), 32'd0);
`endif
        step();
        rst = 1'b0;
        step();
        in_valid = 1'b1;
        for (int k = 60; k < 64; k++) begin
            set_vec(k, 4'b1001);
            step();
        end
        in_valid = 1'b0;
        chk("refill_count", 32'(count), 32'd4);
`ifdef DSA_SIMD_FIFO_HWM_EN
        chk("refill_hwm", 32'(hwm), 32'd4);
`endif
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) step();
        chk("final_empty", 32'(count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
